mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter for the 5-stage pipeline. It shares one external memory port between the IF-stage instruction fetch and the MEM-stage load/store. It sequences each access with a req/ack handshake and latches read data per requester. It drives the `memReady` input of the ID-stage stall controller, so the pipeline freezes until every pending access of the current cycle has completed.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8`

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch request, held stable while `memReady`=0
- `if_addr` in ADDR_W: fetch address
- `if_rdata` out DATA_W: latched instruction
- `dm_req` in 1: data access request, held stable while `memReady`=0
- `dm_we` in 1: 1 = store
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_be` in DATA_W/8: store byte enables
- `dm_rdata` out DATA_W: latched load data
- `flush` in 1: taken branch or trap; the current fetch is discarded
- `mem_req` out 1: external request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` out: registered command, stable while `mem_req`=1
- `mem_rdata` in DATA_W: valid in the `mem_ack` cycle
- `mem_ack` in 1: one-cycle completion pulse; only legal while `mem_req`=1
- `memReady` out 1: combinational; 1 = no unserved request

## Operation
- State machine has four states: IDLE, DATA, IFETCH, DRAIN.
- `if_done` and `dm_done` flags record accesses already completed in the current pipeline cycle.
- `memReady` = !((if_req & !if_done) | (dm_req & !dm_done)) & (state != DRAIN). It is forced to 1 while `reset`=1.
- Both done flags clear in any cycle where `memReady`=1, because the pipeline advances.
- IDLE:
  - If `dm_req & !dm_done`, go to DATA. Register `dm_*` onto `mem_*` and set `mem_req`=1.
  - Otherwise, if `if_req & !if_done & !flush`, go to IFETCH with `mem_we`=0 and `mem_be` all ones.
  - Data always has priority because it belongs to the older instruction.
- DATA, on `mem_ack`:
  - `dm_rdata` <= `mem_rdata`, but only for loads; stores leave `dm_rdata` unchanged.
  - Set `dm_done` and drop `mem_req`.
  - If a fetch is pending and `flush`=0, go directly to IFETCH (back-to-back issue). Otherwise go to IDLE.
- IFETCH:
  - On `mem_ack` with `flush`=0: `if_rdata` <= `mem_rdata`, set `if_done`, go to IDLE, drop `mem_req`.
  - On `flush`=1 before the ack: go to DRAIN. Keep `mem_req` high; the bus transaction is never abandoned.
  - On `flush`=1 in the same cycle as `mem_ack`: discard the data, leave `if_done` clear, go to IDLE.
- DRAIN: on `mem_ack`, discard `mem_rdata` and go to IDLE. The fetch is re-issued using the new `if_addr`.
- `flush` in IDLE or DATA: clear `if_done`; no other effect.
- `flush` has no effect on data accesses.
- `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` change only on transitions into DATA or IFETCH.

## Timing
- Request first seen in IDLE in cycle n: `mem_req`=1 from cycle n+1.
- `mem_ack` may arrive in any cycle k ≥ n+1.
- Read data is visible on `if_rdata`/`dm_rdata` at k+1.
- `memReady` rises in cycle k+1 if nothing else is pending.
- Minimum single-access stall is 2 cycles (`memReady`=0 in n and n+1, 1 in n+2).
- Back-to-back data then fetch: the fetch `mem_req` is continuous across the ack edge, with the address switching at k+1.
- Reset values:
  - state IDLE
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0
  - `if_rdata`=0x00000013 (NOP)
  - `dm_rdata`=0
  - both done flags 0
- Reset mid-transaction: `mem_req`=0 in the next cycle and state returns to IDLE. The memory model must tolerate the aborted request.
- A `mem_ack` while `mem_req`=0 is ignored.

## Structure
- `constants.vh` holds:
  - state encodings `MARB_IDLE`/`MARB_DATA`/`MARB_IFETCH`/`MARB_DRAIN`
  - `NOP_INSTR` (32'h00000013)
- No sub-module: one FSM plus two response registers.
- The bench owns a memory model (`mem_model_tb`) with programmable ack delay.

## Test plan
- Fetch-only test:
  - Stimulus: `if_req`=1, `if_addr`=0x100, ack after 2 cycles with data 0x00500093.
  - Required: `memReady`=0 for 3 cycles, then 1; `if_rdata`=0x00500093; `mem_req` drops.
- Simultaneous requests:
  - Stimulus: load at 0x2000 plus fetch at 0x104.
  - Required: `mem_addr` = 0x2000 first, then 0x104 with no idle cycle; `memReady` high only after both acks; `dm_rdata` and `if_rdata` correct.
- Store:
  - Stimulus: `dm_we`=1, `dm_be`=4'b0011, `dm_wdata`=0xDEADBEEF at 0x3000.
  - Required: `mem_we`=1, `mem_be`=0011, `mem_wdata` stable until ack; `dm_rdata` unchanged.
- Flush during an in-flight fetch:
  - Stimulus: fetch to 0x108; `flush` one cycle after `mem_req` rises; ack 3 cycles later with 0xFFFFFFFF; new `if_addr`=0x400.
  - Required: DRAIN entered; 0xFFFFFFFF never appears on `if_rdata`; a second request is issued at 0x400.
- Zero-wait memory:
  - Stimulus: ack in the first `mem_req` cycle.
  - Required: `memReady` back to 1 two cycles after the request appears.
- Reset mid-transaction:
  - Stimulus: `reset` asserted during DATA.
  - Required: next cycle `mem_req`=0 and `memReady`=1; `if_rdata`=0x00000013.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM state encoding
// and the instruction value presented on if_rdata out of reset.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MARB_IDLE   = 2'd0,
        MARB_DATA   = 2'd1,
        MARB_IFETCH = 2'd2,
        MARB_DRAIN  = 2'd3
    } marbState_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access,
// latching per-requester read data and stalling the pipeline via memReady.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    input  logic                flush,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                memReady
);

    localparam int BE_W = DATA_W / 8;

    marbState_t          state_q, state_d;
    logic                ifDone_q, ifDone_d;
    logic                dmDone_q, dmDone_d;
    logic                memReq_q, memReq_d;
    logic                memWe_q, memWe_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memWdata_q, memWdata_d;
    logic [BE_W-1:0]     memBe_q, memBe_d;
    logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0]   dmRdata_q, dmRdata_d;

    logic ackValid;
    logic ifPending;
    logic dmPending;

    assign ackValid  = mem_ack & memReq_q;
    assign ifPending = if_req & ~ifDone_q;
    assign dmPending = dm_req & ~dmDone_q;
    assign memReady  = reset | (~(ifPending | dmPending) & (state_q != MARB_DRAIN));

    // Next-state and command logic; data wins in IDLE as it belongs to the older instruction.
    always_comb begin
        state_d    = state_q;
        ifDone_d   = ifDone_q;
        dmDone_d   = dmDone_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memBe_d    = memBe_q;
        ifRdata_d  = ifRdata_q;
        dmRdata_d  = dmRdata_q;

        if (memReady) begin
            ifDone_d = 1'b0;
            dmDone_d = 1'b0;
        end

        case (state_q)
            MARB_IDLE: begin
                if (flush) begin
                    ifDone_d = 1'b0;
                end
                if (dmPending) begin
                    state_d    = MARB_DATA;
                    memReq_d   = 1'b1;
                    memWe_d    = dm_we;
                    memAddr_d  = dm_addr;
                    memWdata_d = dm_wdata;
                    memBe_d    = dm_be;
                end else if (ifPending && !flush) begin
                    state_d   = MARB_IFETCH;
                    memReq_d  = 1'b1;
                    memWe_d   = 1'b0;
                    memAddr_d = if_addr;
                    memBe_d   = '1;
                end
            end
            MARB_DATA: begin
                if (flush) begin
                    ifDone_d = 1'b0;
                end
                if (ackValid) begin
                    if (!memWe_q) begin
                        dmRdata_d = mem_rdata;
                    end
                    dmDone_d = 1'b1;
                    // A pending fetch keeps mem_req high across the ack edge.
                    if (ifPending && !flush) begin
                        state_d   = MARB_IFETCH;
                        memWe_d   = 1'b0;
                        memAddr_d = if_addr;
                        memBe_d   = '1;
                    end else begin
                        state_d  = MARB_IDLE;
                        memReq_d = 1'b0;
                    end
                end
            end
            MARB_IFETCH: begin
                if (ackValid) begin
                    state_d  = MARB_IDLE;
                    memReq_d = 1'b0;
                    if (!flush) begin
                        ifRdata_d = mem_rdata;
                        ifDone_d  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = MARB_DRAIN;
                end
            end
            MARB_DRAIN: begin
                if (ackValid) begin
                    state_d  = MARB_IDLE;
                    memReq_d = 1'b0;
                end
            end
            default: begin
                state_d  = MARB_IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= MARB_IDLE;
            ifDone_q   <= 1'b0;
            dmDone_q   <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memBe_q    <= '0;
            ifRdata_q  <= DATA_W'(NOP_INSTR);
            dmRdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ifDone_q   <= ifDone_d;
            dmDone_q   <= dmDone_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memBe_q    <= memBe_d;
            ifRdata_q  <= ifRdata_d;
            dmRdata_q  <= dmRdata_d;
        end
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_be    = memBe_q;
    assign if_rdata  = ifRdata_q;
    assign dm_rdata  = dmRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory model with programmable ack delay, a
// transaction scoreboard, directed vectors and randomized pipeline instructions.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        memReady;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .memReady  (memReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic [3:0]  dmBe;
        int          delay;
        int          expStall;
        logic [31:0] expIf;
        logic [31:0] expDm;
    } vec_t;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] memImg [logic [31:0]];
    txn_t        obsQ[$];
    int          ackDelay = 0;
    int          waitCnt = 0;
    bit          newTxn = 1'b1;

    logic [31:0] expIf;
    logic [31:0] expDm;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memImg.exists(a)) return memImg[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // mem_model_tb: acks each command ackDelay cycles after it first appears.
    always @(negedge clock) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            newTxn  = 1'b1;
        end
        if (mem_req && !reset) begin
            if (newTxn) begin
                waitCnt = ackDelay;
                newTxn  = 1'b0;
            end
            if (waitCnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memRead(mem_addr);
                obsQ.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
            end else begin
                waitCnt = waitCnt - 1;
            end
        end else begin
            newTxn = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one pipeline instruction, waits for memReady and checks bus order.
    task automatic applyStimulus(input vec_t v, output int stall);
        txn_t expQ[$];
        int   n;
        @(posedge clock);
        #1;
        if_req   = v.ifReq;
        if_addr  = v.ifAddr;
        dm_req   = v.dmReq;
        dm_we    = v.dmWe;
        dm_addr  = v.dmAddr;
        dm_wdata = v.dmWdata;
        dm_be    = v.dmBe;
        flush    = 1'b0;
        ackDelay = v.delay;
        obsQ.delete();
        stall = 0;
        @(negedge clock);
        while (!memReady && stall <= 60) begin
            stall++;
            @(negedge clock);
        end
        if (!memReady) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL ready_timeout: memReady still 0 after %0d cycles, expected 1", stall);
        end
        if (v.dmReq) expQ.push_back('{v.dmWe, v.dmAddr, v.dmWdata, v.dmBe});
        if (v.ifReq) expQ.push_back('{1'b0, v.ifAddr, 32'h0, 4'hF});
        checkOutput("txn_count", 32'(obsQ.size()), 32'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("txn_addr", obsQ[i].addr, expQ[i].addr);
            checkOutput("txn_we", 32'(obsQ[i].we), 32'(expQ[i].we));
            checkOutput("txn_be", 32'(obsQ[i].be), 32'(expQ[i].be));
            if (expQ[i].we) checkOutput("txn_wdata", obsQ[i].wdata, expQ[i].wdata);
        end
        checkOutput("req_dropped", 32'(mem_req), 32'h0);
    endtask

    vec_t vecs[6];
    vec_t rv;
    int   stall;
    int   nAcc;
    int   expStall;
    bit   sawBad;
    int   cyc;

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; dm_be = 0; flush = 0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        memImg[32'h100]  = 32'h00500093;
        memImg[32'h104]  = 32'h00A00113;
        memImg[32'h10C]  = 32'h00000517;
        memImg[32'h2000] = 32'h11223344;
        memImg[32'h108]  = 32'hFFFFFFFF;
        memImg[32'h400]  = 32'h00100073;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 3, 32'h00500093, 32'h0};
        vecs[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1, 5, 32'h00A00113, 32'h11223344};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'hDEADBEEF, 4'b0011, 2, 4, 32'h00A00113, 32'h11223344};
        vecs[3] = '{1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 2, 32'h00000517, 32'h11223344};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h00000517, 32'h11223344};
        vecs[5] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h3004, 32'hCAFEF00D, 4'b1100, 0, 3, 32'h00500093, 32'h11223344};

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_ready", 32'(memReady), 32'h1);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
        checkOutput("rst_if_rdata", if_rdata, 32'h00000013);
        checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_ready", 32'(memReady), 32'h1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], stall);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].expIf);
            checkOutput($sformatf("vec%0d_dm_rdata", i), dm_rdata, vecs[i].expDm);
        end
        expIf = 32'h00500093;
        expDm = 32'h11223344;

        // Flush one cycle after the fetch request rises; the bus must drain.
        @(posedge clock);
        #1;
        if_req = 1'b1; if_addr = 32'h108; dm_req = 1'b0; flush = 1'b0;
        ackDelay = 4;
        obsQ.delete();
        sawBad = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("flush_req_up", 32'(mem_req), 32'h1);
        @(posedge clock);
        #1;
        flush = 1'b1; if_addr = 32'h400;
        @(posedge clock);
        #1;
        flush = 1'b0; ackDelay = 1;
        @(negedge clock);
        checkOutput("flush_drain_state", 32'(dut.state_q), 32'(MARB_DRAIN));
        cyc = 0;
        while (!memReady && cyc < 40) begin
            if (if_rdata === 32'hFFFFFFFF) sawBad = 1'b1;
            cyc++;
            @(negedge clock);
        end
        if (if_rdata === 32'hFFFFFFFF) sawBad = 1'b1;
        checkOutput("flush_ready", 32'(memReady), 32'h1);
        checkOutput("flush_no_stale", 32'(sawBad), 32'h0);
        checkOutput("flush_txn_count", 32'(obsQ.size()), 32'h2);
        if (obsQ.size() >= 2) begin
            checkOutput("flush_first_addr", obsQ[0].addr, 32'h108);
            checkOutput("flush_reissue_addr", obsQ[1].addr, 32'h400);
        end
        checkOutput("flush_if_rdata", if_rdata, 32'h00100073);
        expIf = 32'h00100073;

        // Reset while a load is outstanding.
        @(posedge clock);
        #1;
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2004; ackDelay = 5;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rstmid_in_data", 32'(dut.state_q), 32'(MARB_DATA));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rstmid_ready_forced", 32'(memReady), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b0; dm_req = 1'b0;
        @(negedge clock);
        checkOutput("rstmid_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rstmid_ready", 32'(memReady), 32'h1);
        checkOutput("rstmid_if_rdata", if_rdata, 32'h00000013);
        checkOutput("rstmid_state", 32'(dut.state_q), 32'(MARB_IDLE));
        expIf = 32'h00000013;
        expDm = 32'h0;

        // Randomized instructions against the access-count stall model.
        for (int i = 0; i < 150; i++) begin
            rv.ifReq   = ($urandom_range(0, 3) != 0);
            rv.ifAddr  = $urandom & 32'h0000FFFC;
            rv.dmReq   = $urandom_range(0, 1) == 1;
            rv.dmWe    = $urandom_range(0, 1) == 1;
            rv.dmAddr  = ($urandom & 32'h0000FFFC) | 32'h00010000;
            rv.dmWdata = $urandom;
            rv.dmBe    = 4'($urandom_range(0, 15));
            rv.delay   = $urandom_range(0, 3);
            rv.expStall = 0; rv.expIf = 0; rv.expDm = 0;
            applyStimulus(rv, stall);
            nAcc = int'(rv.ifReq) + int'(rv.dmReq);
            expStall = (nAcc == 0) ? 0 : nAcc * (rv.delay + 1) + 1;
            if (rv.ifReq) expIf = memRead(rv.ifAddr);
            if (rv.dmReq && !rv.dmWe) expDm = memRead(rv.dmAddr);
            checkOutput($sformatf("rand%0d_stall", i), 32'(stall), 32'(expStall));
            checkOutput($sformatf("rand%0d_if_rdata", i), if_rdata, expIf);
            checkOutput($sformatf("rand%0d_dm_rdata", i), dm_rdata, expDm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
